cpu_writeback: RTL

Parametrised register-file writeback stage for the multicycle CPU. It takes writeback requests from the control FSM and selects one of four sources: ALU result, data-memory read, link/return PC, or immediate. It waits for data memory with a bounded timeout, then formats sub-word loads and drives one registered write into the register file. Unlike the single-cycle two-way writeback select it supersedes, it has a request handshake, variable memory latency, byte-lane extraction with sign/zero extension and register-0 write suppression.

---
 rtl/cpu_wb_pkg.sv | 16 +
 rtl/wb_load_format.sv | 19 +
 rtl/wb_mux.sv | 15 +
 rtl/cpu_writeback.sv | 122 ++++++++++++
 4 files changed

// File: rtl/cpu_wb_pkg.sv
// Shared encodings for the register-file writeback stage.
package cpu_wb_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_DM   = 2'd1,
    WB_SRC_LINK = 2'd2,
    WB_SRC_IMM  = 2'd3
  } wb_src_e;

  typedef enum logic {
    WB_IDLE    = 1'b0,
    WB_WAIT_DM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_load_format.sv
// Byte-lane extraction with sign/zero extension for sub-word loads.
module wb_load_format #(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0]            data,
  input  logic                     is_byte,
  input  logic [$clog2(DW/8)-1:0]  lane,
  input  logic                     sext,
  output logic [DW-1:0]            fmt_c
);

  logic [7:0] byte_c;

  always_comb begin
    byte_c = data[{lane, 3'b000} +: 8];
    fmt_c  = is_byte ? {{(DW - 8){sext & byte_c[7]}}, byte_c} : data;
  end

endmodule

// File: rtl/wb_mux.sv
// Generic one-hot-free N:1 mux over a packed, lowest-index-first input vector.
module wb_mux #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 2
) (
  input  logic [(DW << CW)-1:0] din,
  input  logic [CW-1:0]         sel,
  output logic [DW-1:0]         dout_c
);

  always_comb begin
    dout_c = din[DW * 32'(sel) +: DW];
  end

endmodule

// File: rtl/cpu_writeback.sv
// Writeback stage: source select, bounded DM wait, load formatting and a
// single registered register-file write per request.
module cpu_writeback
  import cpu_wb_pkg::*;
#(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 15,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wb_valid,
  output logic                    wb_ready,
  input  logic [1:0]              wb_src,
  input  logic [AW-1:0]           wb_rd,
  input  logic                    wb_byte,
  input  logic [$clog2(DW/8)-1:0] wb_lane,
  input  logic                    wb_sext,
  input  logic [DW-1:0]           alu_out,
  input  logic [DW-1:0]           dm_od,
  input  logic                    dm_valid,
  input  logic [DW-1:0]           link,
  input  logic [DW-1:0]           imm,
  output logic                    rf_we,
  output logic [AW-1:0]           rf_wa,
  output logic [DW-1:0]           rf_wd,
  output logic                    dm_err
);

  localparam int unsigned LW = $clog2(DW / 8);
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  wb_state_e     state;
  logic [TW-1:0] cnt;
  logic [AW-1:0] rd_q;
  logic          byte_q;
  logic          sext_q;
  logic [LW-1:0] lane_q;

  logic          wait_dm_c;
  logic          timeout_c;
  logic          wr_en_c;
  logic [1:0]    sel_c;
  logic [AW-1:0] wa_c;
  logic [DW-1:0] dm_fmt_c;
  logic [DW-1:0] wd_c;

  // In WAIT_DM the write targets the latched request, otherwise the live one.
  assign wait_dm_c = (state == WB_WAIT_DM);
  assign wb_ready  = !wait_dm_c && reset;
  assign sel_c     = wait_dm_c ? WB_SRC_DM : wb_src;
  assign wa_c      = wait_dm_c ? rd_q : wb_rd;
  assign wr_en_c   = !(R0_ZERO && (wa_c == '0));
  assign timeout_c = (TIMEOUT != 0) && ((32'(cnt) + 32'd1) >= TIMEOUT);

  wb_load_format #(.DW(DW)) u_fmt (
    .data    (dm_od),
    .is_byte (byte_q),
    .lane    (lane_q),
    .sext    (sext_q),
    .fmt_c   (dm_fmt_c)
  );

  wb_mux #(.DW(DW), .CW(2)) u_mux (
    .din    ({imm, link, dm_fmt_c, alu_out}),
    .sel    (sel_c),
    .dout_c (wd_c)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= WB_IDLE;
      cnt    <= '0;
      rd_q   <= '0;
      byte_q <= 1'b0;
      sext_q <= 1'b0;
      lane_q <= '0;
      rf_we  <= 1'b0;
      rf_wa  <= '0;
      rf_wd  <= '0;
      dm_err <= 1'b0;
    end else begin
      rf_we  <= 1'b0;
      dm_err <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (wb_valid) begin
            rd_q   <= wb_rd;
            byte_q <= wb_byte;
            sext_q <= wb_sext;
            lane_q <= wb_lane;
            if (wb_src == WB_SRC_DM) begin
              state <= WB_WAIT_DM;
              cnt   <= '0;
            end else begin
              rf_we <= wr_en_c;
              rf_wa <= wa_c;
              rf_wd <= wd_c;
            end
          end
        end
        WB_WAIT_DM: begin
          // dm_valid wins over a timeout landing in the same cycle.
          if (dm_valid) begin
            rf_we <= wr_en_c;
            rf_wa <= wa_c;
            rf_wd <= wd_c;
            state <= WB_IDLE;
          end else if (timeout_c) begin
            dm_err <= 1'b1;
            state  <= WB_IDLE;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + TW'(1);
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule
